minx_bus_arbiter: RTL and testbench
===================================

# minx_bus_arbiter

Shares the MINX external system bus between the s1c88 CPU (default owner) and up to NREQ secondary bus masters (PRC copy engine, save-state/debug DMA). It runs the CPU bus_request/bus_ack handshake, grants one requester at a time in round-robin order, and muxes address/data/strobes/bus_status onto the shared bus. It sits in minx between the CPU, the secondary masters and the register/cartridge decode, replacing the two-way bus_ack mux.

## Interface
- NREQ, 2: number of secondary requesters, 1..4.
- MAX_HOLD, 4096: clk_ce cycles a grant may be held before hold_timeout sets.

- clk  in  1  system clock, all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- clk_ce  in  1  clock enable; state advances only when high.
- req  in  NREQ  per-requester bus request, level, held until done.
- grant  out  NREQ  one-hot (or zero) grant.
- req_address  in  NREQ×24  requester address.
- req_data  in  NREQ×8  requester write data.
- req_read / req_write  in  NREQ  requester strobes.
- req_bus_status  in  NREQ×2  requester bus command.
- cpu_address / cpu_data / cpu_read / cpu_write / cpu_bus_status  in  24/8/1/1/2  CPU bus outputs.
- cpu_bus_request  out  1  request to CPU to release the bus.
- cpu_bus_ack  in  1  CPU has released the bus (instruction boundary).
- bus_address / bus_data / bus_read / bus_write / bus_status  out  24/8/1/1/2  shared bus.
- owner  out  3  0 = CPU, k+1 = requester k.
- hold_timeout  out  1  sticky: a grant exceeded MAX_HOLD.
- protocol_error  out  1  sticky: cpu_bus_ack fell during a grant.

## Operation
- States: IDLE, REQ_CPU, GRANT, GAP, RELEASE.
- IDLE: cpu_bus_request=0; any req high -> REQ_CPU.
- REQ_CPU: cpu_bus_request=1; cpu_bus_ack high -> GRANT to selected requester; all req low before ack -> RELEASE.
- Selection: round-robin from index after last_grant (reset last_grant = NREQ-1, so requester 0 wins first); selection made on entering GRANT, latched.
- GRANT: grant[sel]=1, bus = requester sel. req[sel] low -> GAP if another req high, else RELEASE.
- GAP: exactly one clk_ce cycle, grant=0, bus_read=bus_write=0, address/data from CPU; then GRANT to next round-robin winner (cpu_bus_request stays high, no re-handshake).
- RELEASE: cpu_bus_request=0; wait cpu_bus_ack low -> IDLE. New req during RELEASE waits until IDLE.
- Outside GRANT/GAP the bus carries CPU signals unmodified.
- Hold counter: clears on GRANT entry, counts clk_ce cycles in GRANT, saturates at MAX_HOLD; reaching MAX_HOLD sets hold_timeout. Grant is not revoked.
- cpu_bus_ack low while in GRANT or GAP: drop grant, set protocol_error, go RELEASE.
- Sticky flags clear only on reset.

## Timing
- Reset values: grant=0, cpu_bus_request=0, owner=0, hold_timeout=0, protocol_error=0, state IDLE; bus outputs = CPU inputs.
- Registered outputs: grant, cpu_bus_request, owner, flags. Bus mux is combinational from registered owner.
- req rise -> cpu_bus_request high on next clk_ce edge (1 ce cycle).
- cpu_bus_ack sampled high -> grant high on same edge transition (grant visible 1 ce cycle after ack sampled).
- req fall -> grant low next ce edge; handoff adds exactly 1 GAP cycle.
- Simultaneous req rise in IDLE: round-robin decides; req falling in same cycle as cpu_bus_ack rise: no grant, RELEASE.
- Reset asserted mid-grant: all outputs to reset values immediately (async); bus returns to CPU.

## Structure
- Package minx_bus_pkg: state enum, BUS_COMMAND_* constants (shared with s1c88/prc), OWNER_CPU constant.
- Sub-module rr_select (NREQ-wide round-robin picker: req, last_grant -> sel, valid), combinational.
- Hold counter width $clog2(MAX_HOLD+1).

## Test plan
- Single request: req[0]=1 at cycle 0, ack returned 3 cycles after cpu_bus_request -> grant=01 1 cycle after ack, bus_address = req_address[0]=0x1000; req low -> cpu_bus_request low, IDLE after ack falls.
- Contention: req=11 together -> grant 01, then GAP (bus_write=0 one cycle), then 10, then release; repeat -> order 01,10 again.
- Starvation check: req[0] re-raised during grant to 1 -> next grant goes to 0 only after 1 finishes, no requester granted twice in a row while other pends.
- Timeout: MAX_HOLD=8, hold req[1] for 20 cycles -> hold_timeout rises on 8th granted cycle, grant kept.
- Protocol error: drop cpu_bus_ack during grant -> grant=0 next ce, protocol_error=1, cpu_bus_request=0.
- Reset mid-grant: reset_n low asynchronously -> grant=0, cpu_bus_request=0, owner=0 without clock edge; clk_ce=0 stalls all state.

Source files
------------

// File: rtl/minx_bus_pkg.sv
// Shared definitions for the MINX bus arbiter: FSM states, bus command codes
// and the owner encoding used on the owner output.
package minx_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_CPU,
    ST_GRANT,
    ST_GAP,
    ST_RELEASE
  } arb_state_t;

  // bus_status command codes, common to s1c88, prc and the DMA masters
  localparam logic [1:0] BUS_COMMAND_IDLE      = 2'd0;
  localparam logic [1:0] BUS_COMMAND_IRQ_READ  = 2'd1;
  localparam logic [1:0] BUS_COMMAND_MEM_WRITE = 2'd2;
  localparam logic [1:0] BUS_COMMAND_MEM_READ  = 2'd3;

  localparam logic [2:0] OWNER_CPU = 3'd0;

  function automatic logic [2:0] owner_code(input int idx);
    return 3'(idx + 1);
  endfunction

endpackage

// File: rtl/minx_bus_arbiter_rr_select.sv
// Combinational round-robin picker: first requester with req high, scanning
// upward from the index after last_grant and wrapping.
module rr_select #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [IDW-1:0]  sel,
  output logic            valid
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic [NREQ-1:0][IDW-1:0] cand_idx;
  logic [NREQ-1:0]          cand_hit;

  // Candidate gi is (last_grant + gi + 1) mod NREQ; the sum never reaches 2*NREQ
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      logic [IDW:0] cand_sum;
      assign cand_sum     = {1'b0, last_grant} + (IDW+1)'(gi + 1);
      assign cand_idx[gi] = (cand_sum >= NREQ_W) ? IDW'(cand_sum - NREQ_W)
                                                 : cand_sum[IDW-1:0];
      assign cand_hit[gi] = req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    sel   = last_grant;
    valid = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (cand_hit[i]) begin
        sel   = cand_idx[i];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/minx_bus_arbiter.sv
// MINX system bus arbiter: CPU owns the bus by default; secondary masters are
// granted one at a time in round-robin order after the bus_request/bus_ack handshake.
module minx_bus_arbiter
  import minx_bus_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int MAX_HOLD = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_ce,
  input  logic [NREQ-1:0]       req,
  output logic [NREQ-1:0]       grant,
  input  logic [NREQ-1:0][23:0] req_address,
  input  logic [NREQ-1:0][7:0]  req_data,
  input  logic [NREQ-1:0]       req_read,
  input  logic [NREQ-1:0]       req_write,
  input  logic [NREQ-1:0][1:0]  req_bus_status,
  input  logic [23:0]           cpu_address,
  input  logic [7:0]            cpu_data,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [1:0]            cpu_bus_status,
  output logic                  cpu_bus_request,
  input  logic                  cpu_bus_ack,
  output logic [23:0]           bus_address,
  output logic [7:0]            bus_data,
  output logic                  bus_read,
  output logic                  bus_write,
  output logic [1:0]            bus_status,
  output logic [2:0]            owner,
  output logic                  hold_timeout,
  output logic                  protocol_error
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HCW = $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);

  arb_state_t      state_reg, state_next;
  logic [NREQ-1:0] grant_reg, grant_next;
  logic [2:0]      owner_reg, owner_next;
  logic            cpu_bus_request_reg, cpu_bus_request_next;
  logic [IDW-1:0]  last_grant_reg, last_grant_next;
  logic [HCW-1:0]  hold_cnt_reg, hold_cnt_next;
  logic            hold_timeout_reg, hold_timeout_next;
  logic            protocol_error_reg, protocol_error_next;

  logic [IDW-1:0]  rr_sel;
  logic            rr_valid;
  logic            grant_enter;
  logic [NREQ-1:0] owner_hit;

  rr_select #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_select (
    .req        (req),
    .last_grant (last_grant_reg),
    .sel        (rr_sel),
    .valid      (rr_valid)
  );

  // last_grant_reg doubles as the index of the current holder while in GRANT
  always_comb begin
    state_next           = state_reg;
    grant_next           = grant_reg;
    owner_next           = owner_reg;
    cpu_bus_request_next = cpu_bus_request_reg;
    last_grant_next      = last_grant_reg;
    protocol_error_next  = protocol_error_reg;
    grant_enter          = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (|req) begin
          state_next           = ST_REQ_CPU;
          cpu_bus_request_next = 1'b1;
        end
      end
      ST_REQ_CPU: begin
        // A request withdrawn in the same cycle the ack arrives is not granted
        if (!(|req)) begin
          state_next           = ST_RELEASE;
          cpu_bus_request_next = 1'b0;
        end else if (cpu_bus_ack) begin
          grant_enter = 1'b1;
        end
      end
      ST_GRANT, ST_GAP: begin
        if (!cpu_bus_ack) begin
          state_next           = ST_RELEASE;
          grant_next           = '0;
          owner_next           = OWNER_CPU;
          cpu_bus_request_next = 1'b0;
          protocol_error_next  = 1'b1;
        end else if (state_reg == ST_GAP) begin
          if (rr_valid) begin
            grant_enter = 1'b1;
          end else begin
            state_next           = ST_RELEASE;
            cpu_bus_request_next = 1'b0;
          end
        end else if (!req[last_grant_reg]) begin
          grant_next = '0;
          owner_next = OWNER_CPU;
          if (|req) begin
            state_next = ST_GAP;
          end else begin
            state_next           = ST_RELEASE;
            cpu_bus_request_next = 1'b0;
          end
        end
      end
      ST_RELEASE: begin
        if (!cpu_bus_ack) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (grant_enter) begin
      state_next         = ST_GRANT;
      last_grant_next    = rr_sel;
      grant_next         = '0;
      grant_next[rr_sel] = 1'b1;
      owner_next         = owner_code(int'(rr_sel));
    end
  end

  // Hold counter saturates so the flag stays meaningful on very long grants
  always_comb begin
    hold_cnt_next = hold_cnt_reg;
    if (grant_enter) begin
      hold_cnt_next = '0;
    end else if (state_reg == ST_GRANT && hold_cnt_reg != HOLD_MAX) begin
      hold_cnt_next = hold_cnt_reg + HCW'(1);
    end
    hold_timeout_next = hold_timeout_reg | (hold_cnt_next == HOLD_MAX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg           <= ST_IDLE;
      grant_reg           <= '0;
      owner_reg           <= OWNER_CPU;
      cpu_bus_request_reg <= 1'b0;
      last_grant_reg      <= IDW'(NREQ - 1);
      hold_cnt_reg        <= '0;
      hold_timeout_reg    <= 1'b0;
      protocol_error_reg  <= 1'b0;
    end else if (clk_ce) begin
      state_reg           <= state_next;
      grant_reg           <= grant_next;
      owner_reg           <= owner_next;
      cpu_bus_request_reg <= cpu_bus_request_next;
      last_grant_reg      <= last_grant_next;
      hold_cnt_reg        <= hold_cnt_next;
      hold_timeout_reg    <= hold_timeout_next;
      protocol_error_reg  <= protocol_error_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_owner_hit
      assign owner_hit[gi] = (owner_reg == owner_code(gi));
    end
  endgenerate

  // Shared-bus mux keyed off the registered owner; the GAP cycle keeps CPU
  // address/data but suppresses both strobes
  always_comb begin
    bus_address = cpu_address;
    bus_data    = cpu_data;
    bus_read    = cpu_read;
    bus_write   = cpu_write;
    bus_status  = cpu_bus_status;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_hit[i]) begin
        bus_address = req_address[i];
        bus_data    = req_data[i];
        bus_read    = req_read[i];
        bus_write   = req_write[i];
        bus_status  = req_bus_status[i];
      end
    end
    if (state_reg == ST_GAP) begin
      bus_read  = 1'b0;
      bus_write = 1'b0;
    end
  end

  assign grant           = grant_reg;
  assign owner           = owner_reg;
  assign cpu_bus_request = cpu_bus_request_reg;
  assign hold_timeout    = hold_timeout_reg;
  assign protocol_error  = protocol_error_reg;

endmodule

// File: tb/tb_minx_bus_arbiter.sv
// Bench for minx_bus_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural arbitration model.
module tb_minx_bus_arbiter;

  localparam int NREQ     = 2;
  localparam int MAX_HOLD = 8;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  clk_ce = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0][23:0] req_address = '0;
  logic [NREQ-1:0][7:0]  req_data = '0;
  logic [NREQ-1:0]       req_read = '0;
  logic [NREQ-1:0]       req_write = '0;
  logic [NREQ-1:0][1:0]  req_bus_status = '0;
  logic [23:0]           cpu_address = '0;
  logic [7:0]            cpu_data = '0;
  logic                  cpu_read = 1'b0;
  logic                  cpu_write = 1'b0;
  logic [1:0]            cpu_bus_status = '0;
  logic                  cpu_bus_request;
  logic                  cpu_bus_ack = 1'b0;
  logic [23:0]           bus_address;
  logic [7:0]            bus_data;
  logic                  bus_read;
  logic                  bus_write;
  logic [1:0]            bus_status;
  logic [2:0]            owner;
  logic                  hold_timeout;
  logic                  protocol_error;

  int nvec  = 0;
  int nfail = 0;

  minx_bus_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .clk_ce(clk_ce), .req(req), .grant(grant),
    .req_address(req_address), .req_data(req_data), .req_read(req_read),
    .req_write(req_write), .req_bus_status(req_bus_status),
    .cpu_address(cpu_address), .cpu_data(cpu_data), .cpu_read(cpu_read),
    .cpu_write(cpu_write), .cpu_bus_status(cpu_bus_status),
    .cpu_bus_request(cpu_bus_request), .cpu_bus_ack(cpu_bus_ack),
    .bus_address(bus_address), .bus_data(bus_data), .bus_read(bus_read),
    .bus_write(bus_write), .bus_status(bus_status), .owner(owner),
    .hold_timeout(hold_timeout), .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  // Reference model: who holds the bus, whether the CPU has been asked,
  // whether we are in the one-cycle handoff gap or waiting for ack to drop.
  int m_holder;
  int m_last;
  int m_held;
  bit m_gap, m_asked, m_releasing, m_tmo, m_perr;

  task automatic model_reset();
    m_holder = -1; m_last = NREQ - 1; m_held = 0;
    m_gap = 0; m_asked = 0; m_releasing = 0; m_tmo = 0; m_perr = 0;
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    for (int i = 1; i <= NREQ; i++)
      if (r[(last + i) % NREQ]) return (last + i) % NREQ;
    return -1;
  endfunction

  task automatic model_step();
    int w;
    if (m_holder >= 0) begin
      if (m_held < MAX_HOLD) m_held++;
      if (m_held >= MAX_HOLD) m_tmo = 1;
    end
    if (m_holder >= 0 || m_gap) begin
      if (!cpu_bus_ack) begin
        m_perr = 1; m_holder = -1; m_gap = 0; m_asked = 0; m_releasing = 1;
      end else if (m_gap) begin
        m_gap = 0;
        w = rr_pick(req, m_last);
        if (w >= 0) begin m_holder = w; m_last = w; m_held = 0; end
        else begin m_asked = 0; m_releasing = 1; end
      end else if (!req[m_holder]) begin
        m_holder = -1;
        if (req != '0) m_gap = 1;
        else begin m_asked = 0; m_releasing = 1; end
      end
    end else if (m_releasing) begin
      if (!cpu_bus_ack) m_releasing = 0;
    end else if (!m_asked) begin
      if (req != '0) m_asked = 1;
    end else begin
      if (req == '0) begin m_asked = 0; m_releasing = 1; end
      else if (cpu_bus_ack) begin
        w = rr_pick(req, m_last);
        m_holder = w; m_last = w; m_held = 0;
      end
    end
  endtask

  function automatic logic [NREQ+5:0] exp_ctrl();
    logic [NREQ-1:0] g = '0;
    logic [2:0] o = 3'd0;
    if (m_holder >= 0) begin g[m_holder] = 1'b1; o = 3'(m_holder + 1); end
    return {g, o, m_asked, m_tmo, m_perr};
  endfunction

  function automatic logic [35:0] exp_bus();
    if (m_holder >= 0)
      return {req_address[m_holder], req_data[m_holder], req_read[m_holder],
              req_write[m_holder], req_bus_status[m_holder]};
    if (m_gap) return {cpu_address, cpu_data, 2'b00, cpu_bus_status};
    return {cpu_address, cpu_data, cpu_read, cpu_write, cpu_bus_status};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset_n && clk_ce) model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req = '0; cpu_bus_ack = 1'b0; clk_ce = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cpu_address = 24'h05a5a5; cpu_data = 8'h3c;
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_bus_status = 2'b11;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    nvec++; if (grant !== 2'b00) begin nfail++; $display("FAIL reset_grant: got %b want 00", grant); end
    nvec++; if (cpu_bus_request !== 1'b0) begin nfail++; $display("FAIL reset_cbr: got %b want 0", cpu_bus_request); end
    nvec++; if (owner !== 3'd0) begin nfail++; $display("FAIL reset_owner: got %0d want 0", owner); end
    nvec++; if ({hold_timeout, protocol_error} !== 2'b00) begin nfail++; $display("FAIL reset_flags: got %b want 00", {hold_timeout, protocol_error}); end
    nvec++; if ({bus_address, bus_data, bus_read, bus_status} !== {24'h05a5a5, 8'h3c, 1'b1, 2'b11}) begin
      nfail++; $display("FAIL reset_bus: got %h/%h/%b/%b want 05a5a5/3c/1/11", bus_address, bus_data, bus_read, bus_status);
    end
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req_address[0] = 24'h001000; req_write[0] = 1'b1; req_read[0] = 1'b0;
    cpu_address = 24'h0abcde; cpu_write = 1'b0;
    req = 2'b01; tick();
    nvec++; if ({cpu_bus_request, grant} !== 3'b100) begin nfail++; $display("FAIL single_request: got cbr/grant %b want 100", {cpu_bus_request, grant}); end
    tick(); tick();
    cpu_bus_ack = 1'b1; tick();
    nvec++; if (grant !== 2'b01) begin nfail++; $display("FAIL single_grant: got %b want 01", grant); end
    nvec++; if (owner !== 3'd1) begin nfail++; $display("FAIL single_owner: got %0d want 1", owner); end
    nvec++; if ({bus_address, bus_write} !== {24'h001000, 1'b1}) begin nfail++; $display("FAIL single_bus: got %h/%b want 001000/1", bus_address, bus_write); end
    req = 2'b00; tick();
    nvec++; if ({cpu_bus_request, grant} !== 3'b000) begin nfail++; $display("FAIL single_release: got cbr/grant %b want 000", {cpu_bus_request, grant}); end
    nvec++; if (bus_address !== 24'h0abcde) begin nfail++; $display("FAIL single_bus_cpu: got %h want 0abcde", bus_address); end
    tick();
    cpu_bus_ack = 1'b0; tick();
    req = 2'b01; tick();
    nvec++; if (cpu_bus_request !== 1'b1) begin nfail++; $display("FAIL single_idle_again: got %b want 1", cpu_bus_request); end
    req = 2'b00; tick();
    nvec++; if (cpu_bus_request !== 1'b0) begin nfail++; $display("FAIL single_withdraw: got %b want 0", cpu_bus_request); end
    tick();
  endtask

  task automatic test_contention();
    do_reset();
    cpu_write = 1'b1; cpu_address = 24'h00beef;
    for (int round = 0; round < 2; round++) begin
      req = 2'b11; tick();
      cpu_bus_ack = 1'b1; tick();
      nvec++; if (grant !== 2'b01) begin nfail++; $display("FAIL cont_first r%0d: got %b want 01", round, grant); end
      tick();
      req = 2'b10; tick();
      nvec++; if ({grant, bus_write, cpu_bus_request} !== 4'b0001) begin nfail++; $display("FAIL cont_gap r%0d: got grant/wr/cbr %b want 0001", round, {grant, bus_write, cpu_bus_request}); end
      nvec++; if (bus_address !== 24'h00beef) begin nfail++; $display("FAIL cont_gap_addr r%0d: got %h want 00beef", round, bus_address); end
      tick();
      nvec++; if ({grant, owner} !== {2'b10, 3'd2}) begin nfail++; $display("FAIL cont_second r%0d: got %b/%0d want 10/2", round, grant, owner); end
      req = 2'b00; tick();
      nvec++; if ({grant, cpu_bus_request} !== 3'b000) begin nfail++; $display("FAIL cont_release r%0d: got %b want 000", round, {grant, cpu_bus_request}); end
      cpu_bus_ack = 1'b0; tick();
    end
  endtask

  task automatic test_starvation();
    do_reset();
    req = 2'b11; tick();
    cpu_bus_ack = 1'b1; tick();
    req = 2'b10; tick(); tick();
    nvec++; if (grant !== 2'b10) begin nfail++; $display("FAIL starve_to1: got %b want 10", grant); end
    req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++; if (grant !== 2'b10) begin nfail++; $display("FAIL starve_keep%0d: got %b want 10", i, grant); end
    end
    req = 2'b01; tick();
    nvec++; if (grant !== 2'b00) begin nfail++; $display("FAIL starve_gap: got %b want 00", grant); end
    tick();
    nvec++; if (grant !== 2'b01) begin nfail++; $display("FAIL starve_back0: got %b want 01", grant); end
    req = 2'b00; tick();
    cpu_bus_ack = 1'b0; tick();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 2'b10; tick();
    cpu_bus_ack = 1'b1; tick();
    for (int c = 1; c <= 20; c++) begin
      nvec++; if ({grant, hold_timeout} !== {2'b10, (c > MAX_HOLD)}) begin
        nfail++; $display("FAIL timeout_c%0d: got grant/tmo %b/%b want 10/%b", c, grant, hold_timeout, (c > MAX_HOLD));
      end
      tick();
    end
    req = 2'b00; tick();
    nvec++; if ({grant, hold_timeout} !== 3'b001) begin nfail++; $display("FAIL timeout_sticky: got %b want 001", {grant, hold_timeout}); end
    cpu_bus_ack = 1'b0; tick();
  endtask

  task automatic test_protocol_error();
    do_reset();
    req = 2'b01; tick();
    cpu_bus_ack = 1'b1; tick();
    nvec++; if ({grant, protocol_error} !== 3'b010) begin nfail++; $display("FAIL perr_pre: got %b want 010", {grant, protocol_error}); end
    cpu_bus_ack = 1'b0; tick();
    nvec++; if ({grant, protocol_error, cpu_bus_request, owner} !== {2'b00, 1'b1, 1'b0, 3'd0}) begin
      nfail++; $display("FAIL perr_drop: got grant/perr/cbr/owner %b/%b/%b/%0d want 00/1/0/0", grant, protocol_error, cpu_bus_request, owner);
    end
    tick(); tick();
    nvec++; if ({cpu_bus_request, protocol_error} !== 2'b11) begin nfail++; $display("FAIL perr_sticky: got cbr/perr %b want 11", {cpu_bus_request, protocol_error}); end
    req = 2'b00; tick(); tick();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    cpu_address = 24'h0c0ffe; req_address[0] = 24'h012345;
    req = 2'b01; tick();
    cpu_bus_ack = 1'b1; tick();
    nvec++; if (bus_address !== 24'h012345) begin nfail++; $display("FAIL arst_pre: got %h want 012345", bus_address); end
    #2 reset_n = 1'b0;
    #1;
    nvec++; if ({grant, cpu_bus_request, owner} !== 6'b000000) begin nfail++; $display("FAIL arst_outputs: got grant/cbr/owner %b/%b/%0d want 00/0/0", grant, cpu_bus_request, owner); end
    nvec++; if (bus_address !== 24'h0c0ffe) begin nfail++; $display("FAIL arst_bus: got %h want 0c0ffe", bus_address); end
    model_reset();
    req = 2'b00; cpu_bus_ack = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_ce_stall();
    do_reset();
    req = 2'b01; tick();
    cpu_bus_ack = 1'b1; tick();
    clk_ce = 1'b0; req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      nvec++; if (grant !== 2'b01) begin nfail++; $display("FAIL stall_grant%0d: got %b want 01", i, grant); end
    end
    clk_ce = 1'b1; tick();
    nvec++; if ({grant, cpu_bus_request} !== 3'b000) begin nfail++; $display("FAIL stall_resume: got %b want 000", {grant, cpu_bus_request}); end
    cpu_bus_ack = 1'b0; tick();
    clk_ce = 1'b0; req = 2'b01; tick(); tick();
    nvec++; if (cpu_bus_request !== 1'b0) begin nfail++; $display("FAIL stall_idle: got %b want 0", cpu_bus_request); end
    clk_ce = 1'b1; tick();
    nvec++; if (cpu_bus_request !== 1'b1) begin nfail++; $display("FAIL stall_idle_resume: got %b want 1", cpu_bus_request); end
    req = 2'b00; tick(); tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 499) == 0) begin
        #2 reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
      end
      clk_ce = ($urandom_range(0, 4) != 0);
      cpu_address = 24'($urandom); cpu_data = 8'($urandom);
      cpu_read = 1'($urandom); cpu_write = 1'($urandom); cpu_bus_status = 2'($urandom);
      for (int k = 0; k < NREQ; k++) begin
        req_address[k] = 24'($urandom); req_data[k] = 8'($urandom);
        req_read[k] = 1'($urandom); req_write[k] = 1'($urandom);
        req_bus_status[k] = 2'($urandom);
        if (!req[k]) req[k] = ($urandom_range(0, 4) == 0);
        else if (m_holder == k && $urandom_range(0, 5) == 0) req[k] = 1'b0;
      end
      if (cpu_bus_request && !cpu_bus_ack) cpu_bus_ack = ($urandom_range(0, 2) == 0);
      else if (!cpu_bus_request && cpu_bus_ack) cpu_bus_ack = ($urandom_range(0, 2) == 0);
      else if (cpu_bus_request && cpu_bus_ack && $urandom_range(0, 149) == 0) cpu_bus_ack = 1'b0;
      #1;
      nvec++;
      if ({grant, owner, cpu_bus_request, hold_timeout, protocol_error} !== exp_ctrl()) begin
        nfail++;
        $display("FAIL rand_ctrl cyc %0d: got %b want %b", cyc,
                 {grant, owner, cpu_bus_request, hold_timeout, protocol_error}, exp_ctrl());
      end
      nvec++;
      if ({bus_address, bus_data, bus_read, bus_write, bus_status} !== exp_bus()) begin
        nfail++;
        $display("FAIL rand_bus cyc %0d: got %h want %h", cyc,
                 {bus_address, bus_data, bus_read, bus_write, bus_status}, exp_bus());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_starvation();
    test_timeout();
    test_protocol_error();
    test_reset_mid_grant();
    test_ce_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
